uart_tx_param: RTL and testbench

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_cnt.sv | 36 +++
 rtl/uart_tx_param.sv | 154 +++++++++++++++
 tb/tb_uart_tx_param.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART transmitter types, constants and frame-length
//                helper for the design and its bench.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int   DEFAULT_CLKS_PER_BIT = 27;
  localparam logic PARITY_EVEN          = 1'b0;
  localparam logic PARITY_ODD           = 1'b1;

  // Number of bit periods in one frame: start + data + optional parity + stops.
  function automatic int frame_bits(input int data_w, input logic parity_en,
                                    input logic stop2);
    return 2 + data_w + (parity_en ? 1 : 0) + (stop2 ? 1 : 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_cnt
//  Description : Bit-period counter. Counts 0..CLKS_PER_BIT-1 and flags the
//                last cycle of each bit period; held at zero by restart.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 27
) (
  input  logic clk_3125,
  input  logic rst_n,
  input  logic restart,
  output logic bit_end
);

  localparam int              CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running period counter, cleared while the transmitter is idle.
  always_ff @(posedge clk_3125) begin
    if (!rst_n || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bit_end = !restart && (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_param
//  Description : Parameterised UART transmitter with optional parity, one or
//                two stop bits and selectable bit order. All outputs are
//                registered; tx idles high.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int MSB_FIRST    = 1
) (
  input  logic              clk_3125,
  input  logic              rst_n,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] data,
  input  logic              parity_en,
  input  logic              parity_type,
  input  logic              stop2,
  output logic              tx,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int               IDX_W    = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  bit_idx;
  logic [1:0]        tail_left;   // bit periods still to send after the current parity/stop bit
  logic              par_en_q;
  logic              stop2_q;
  logic              parity_bit;
  logic              restart;
  logic              bit_end;
  logic              next_bit;
  logic [DATA_W-1:0] shreg_shifted;

  assign restart = (state == IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_3125(clk_3125),
    .rst_n   (rst_n),
    .restart (restart),
    .bit_end (bit_end)
  );

  // Bit order only changes which end of the shift register is sent first.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign next_bit      = shreg[DATA_W-1];
      assign shreg_shifted = {shreg[DATA_W-2:0], 1'b0};
    end else begin : g_lsb_first
      assign next_bit      = shreg[0];
      assign shreg_shifted = {1'b0, shreg[DATA_W-1:1]};
    end
  endgenerate

  // Frame sequencer: latches the request, then walks START/DATA/PARITY/STOP.
  always_ff @(posedge clk_3125) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx         <= 1'b1;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      shreg      <= '0;
      bit_idx    <= '0;
      tail_left  <= 2'd0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      parity_bit <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (tx_start) begin
            shreg      <= data;
            par_en_q   <= parity_en;
            stop2_q    <= stop2;
            parity_bit <= (parity_type == PARITY_ODD) ? ~^data : ^data;
            bit_idx    <= '0;
            tx         <= 1'b0;
            tx_ready   <= 1'b0;
            tx_busy    <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx    <= next_bit;
            shreg <= shreg_shifted;
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == LAST_IDX) begin
              tail_left <= 2'(frame_bits(DATA_W, par_en_q, stop2_q) - DATA_W - 2);
              if (par_en_q) begin
                tx    <= parity_bit;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              tx      <= next_bit;
              shreg   <= shreg_shifted;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            tail_left <= tail_left - 2'd1;
            tx        <= 1'b1;
            state     <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (tail_left == 2'd0) begin
              tx       <= 1'b1;
              tx_done  <= 1'b1;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
              bit_idx  <= '0;
              state    <= IDLE;
            end else begin
              tail_left <= tail_left - 2'd1;
            end
          end
        end
        default: begin
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_param
//  Description : Directed bench for uart_tx_param: a default-parameter
//                instance and a 7-bit / LSB-first / 4-clock instance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_param;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic       sel_b;
  logic [7:0] data;
  logic       pe, pt, s2;

  logic a_start, b_start;
  logic a_tx, a_ready, a_busy, a_done;
  logic b_tx, b_ready, b_busy, b_done;
  logic cur_tx, cur_ready, cur_busy, cur_done;

  assign a_start   = start & ~sel_b;
  assign b_start   = start & sel_b;
  assign cur_tx    = sel_b ? b_tx    : a_tx;
  assign cur_ready = sel_b ? b_ready : a_ready;
  assign cur_busy  = sel_b ? b_busy  : a_busy;
  assign cur_done  = sel_b ? b_done  : a_done;

  uart_tx_param u_a (
    .clk_3125   (clk),
    .rst_n      (rst_n),
    .tx_start   (a_start),
    .data       (data),
    .parity_en  (pe),
    .parity_type(pt),
    .stop2      (s2),
    .tx         (a_tx),
    .tx_ready   (a_ready),
    .tx_busy    (a_busy),
    .tx_done    (a_done)
  );

  uart_tx_param #(
    .DATA_W      (7),
    .CLKS_PER_BIT(4),
    .MSB_FIRST   (0)
  ) u_b (
    .clk_3125   (clk),
    .rst_n      (rst_n),
    .tx_start   (b_start),
    .data       (data[6:0]),
    .parity_en  (pe),
    .parity_type(pt),
    .stop2      (s2),
    .tx         (b_tx),
    .tx_ready   (b_ready),
    .tx_busy    (b_busy),
    .tx_done    (b_done)
  );

  // Expected line bits are written first-to-last from the left; the unused
  // right-hand positions hold 1 (idle line).
  typedef struct {
    logic        use_b;
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    logic        s2;
    logic [11:0] exp_bits;
    int          exp_cycles;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete frame on the selected instance, with a stray mid-frame
  // request and scrambled inputs after accept.
  task automatic run_vec(input vec_t v, input int id);
    int cpb;
    cpb = v.use_b ? 4 : 27;
    @(negedge clk);
    sel_b = v.use_b;
    data  = v.data;
    pe    = v.pe;
    pt    = v.pt;
    s2    = v.s2;
    check($sformatf("v%0d ready_before", id), 32'(cur_ready), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data  = ~v.data;
    pe    = ~v.pe;
    pt    = ~v.pt;
    s2    = ~v.s2;
    check($sformatf("v%0d busy_start", id), 32'(cur_busy), 32'd1);
    check($sformatf("v%0d ready_start", id), 32'(cur_ready), 32'd0);
    for (int k = 0; k < v.exp_cycles; k++) begin
      if (k > 0) @(negedge clk);
      start = (k == v.exp_cycles / 2);
      check($sformatf("v%0d tx k=%0d", id, k), 32'(cur_tx), 32'(v.exp_bits[11 - (k / cpb)]));
      check($sformatf("v%0d done_early k=%0d", id, k), 32'(cur_done), 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    check($sformatf("v%0d done", id), 32'(cur_done), 32'd1);
    check($sformatf("v%0d ready_end", id), 32'(cur_ready), 32'd1);
    check($sformatf("v%0d busy_end", id), 32'(cur_busy), 32'd0);
    check($sformatf("v%0d tx_end", id), 32'(cur_tx), 32'd1);
    @(negedge clk);
    check($sformatf("v%0d done_once", id), 32'(cur_done), 32'd0);
    check($sformatf("v%0d idle_tx", id), 32'(cur_tx), 32'd1);
    check($sformatf("v%0d not_queued", id), 32'(cur_ready), 32'd1);
  endtask

  initial begin
    logic [11:0] exp1;
    logic [11:0] exp2;
    int          len;

    vecs[0] = '{use_b:1'b0, data:8'hA5, pe:1'b1, pt:1'b0, s2:1'b0, exp_bits:12'b0101_0010_1011, exp_cycles:297};
    vecs[1] = '{use_b:1'b0, data:8'hA5, pe:1'b1, pt:1'b1, s2:1'b0, exp_bits:12'b0101_0010_1111, exp_cycles:297};
    vecs[2] = '{use_b:1'b0, data:8'hA5, pe:1'b0, pt:1'b0, s2:1'b1, exp_bits:12'b0101_0010_1111, exp_cycles:297};
    vecs[3] = '{use_b:1'b0, data:8'h00, pe:1'b1, pt:1'b1, s2:1'b1, exp_bits:12'b0000_0000_0111, exp_cycles:324};
    vecs[4] = '{use_b:1'b0, data:8'hFF, pe:1'b1, pt:1'b0, s2:1'b0, exp_bits:12'b0111_1111_1011, exp_cycles:297};
    vecs[5] = '{use_b:1'b0, data:8'h5A, pe:1'b0, pt:1'b0, s2:1'b0, exp_bits:12'b0010_1101_0111, exp_cycles:270};
    vecs[6] = '{use_b:1'b1, data:8'h41, pe:1'b0, pt:1'b0, s2:1'b0, exp_bits:12'b0100_0001_1111, exp_cycles:36};
    vecs[7] = '{use_b:1'b1, data:8'h35, pe:1'b1, pt:1'b1, s2:1'b1, exp_bits:12'b0101_0110_1111, exp_cycles:44};

    // Reset with a simultaneous request: both instances must stay idle.
    rst_n = 1'b0;
    start = 1'b1;
    sel_b = 1'b0;
    data  = 8'hA5;
    pe    = 1'b0;
    pt    = 1'b0;
    s2    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst a_tx", 32'(a_tx), 32'd1);
    check("rst a_ready", 32'(a_ready), 32'd1);
    check("rst a_busy", 32'(a_busy), 32'd0);
    check("rst a_done", 32'(a_done), 32'd0);
    check("rst b_tx", 32'(b_tx), 32'd1);
    check("rst b_ready", 32'(b_ready), 32'd1);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("rst start_ignored busy", 32'(a_busy), 32'd0);
    check("rst start_ignored tx", 32'(a_tx), 32'd1);

    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i], i);
    end

    // Back-to-back frames with the request held high throughout.
    @(negedge clk);
    sel_b = 1'b0;
    data  = 8'h00;
    pe    = 1'b0;
    pt    = 1'b0;
    s2    = 1'b0;
    start = 1'b1;
    @(negedge clk);
    data = 8'hFF;
    exp1 = 12'b0000_0000_0111;
    exp2 = 12'b0111_1111_1111;
    len  = frame_bits(8, 1'b0, 1'b0) * 27;
    for (int k = 0; k < len; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("b2b f1 tx k=%0d", k), 32'(a_tx), 32'(exp1[11 - (k / 27)]));
      check($sformatf("b2b f1 busy k=%0d", k), 32'(a_busy), 32'd1);
    end
    @(negedge clk);
    check("b2b f1 done", 32'(a_done), 32'd1);
    check("b2b f1 ready", 32'(a_ready), 32'd1);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < len; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("b2b f2 tx k=%0d", k), 32'(a_tx), 32'(exp2[11 - (k / 27)]));
      check($sformatf("b2b f2 done k=%0d", k), 32'(a_done), 32'd0);
    end
    @(negedge clk);
    check("b2b f2 done", 32'(a_done), 32'd1);
    @(negedge clk);
    check("b2b idle ready", 32'(a_ready), 32'd1);
    check("b2b idle tx", 32'(a_tx), 32'd1);

    // Reset pulse during data bit 3 aborts the frame.
    @(negedge clk);
    sel_b = 1'b0;
    data  = 8'hC3;
    pe    = 1'b0;
    s2    = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (110) @(negedge clk);
    check("abort bit3 tx", 32'(a_tx), 32'd0);
    check("abort bit3 busy", 32'(a_busy), 32'd1);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    check("abort tx", 32'(a_tx), 32'd1);
    check("abort ready", 32'(a_ready), 32'd1);
    check("abort busy", 32'(a_busy), 32'd0);
    check("abort done", 32'(a_done), 32'd0);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      check($sformatf("abort quiet tx k=%0d", k), 32'(a_tx), 32'd1);
      check($sformatf("abort quiet done k=%0d", k), 32'(a_done), 32'd0);
    end
    run_vec(vecs[5], 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
